octant_fold_div: RTL and testbench

OCTANT_FOLD_DIV -- requirements
Module: octant_fold_div

---
 rtl/octant_fold_div_if.sv | 26 ++
 rtl/octant_fold_div.sv | 134 +++++++++++++
 tb/tb_octant_fold_div.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/octant_fold_div_if.sv
// Handshake bundle for octant_fold_div: sample in (val/rdy), fold-ratio
// result out (val/rdy).
interface octant_fold_div_if #(
  parameter int W    = 8,
  parameter int FRAC = 7
);
  logic                val_i;
  logic                rdy_o;
  logic signed [W-1:0] real_i;
  logic signed [W-1:0] imag_i;
  logic                val_o;
  logic                rdy_i;
  logic [FRAC:0]       ratio_o;
  logic [2:0]          case_flag;
  logic                zero_o;

  modport slave (
    input  val_i, real_i, imag_i, rdy_i,
    output rdy_o, val_o, ratio_o, case_flag, zero_o
  );

  modport master (
    output val_i, real_i, imag_i, rdy_i,
    input  rdy_o, val_o, ratio_o, case_flag, zero_o
  );
endinterface

// File: rtl/octant_fold_div.sv
// Folds a complex sample into the first octant and computes the
// min/max magnitude ratio with a serial restoring divider.
module octant_fold_div #(
  parameter int W    = 8,
  parameter int FRAC = 7
) (
  input logic               clk,
  input logic               rst,
  octant_fold_div_if.slave  bus
);

  localparam int CW = $clog2(FRAC + 1);

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  state_t        r_state;
  state_t        w_next;

  logic [W-1:0]  r_absRe;
  logic [W-1:0]  r_absIm;
  logic          r_reNeg;
  logic          r_imNeg;
  logic [W-1:0]  r_den;
  logic [W:0]    r_rem;
  logic [FRAC-1:0] r_quo;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_caseP;
  logic          r_zeroP;

  logic          r_rdy;
  logic          r_val;
  logic [FRAC:0] r_ratio;
  logic [2:0]    r_case;
  logic          r_zero;

  logic [W-1:0]  w_absRe;
  logic [W-1:0]  w_absIm;
  logic          w_imGtRe;
  logic          w_bothZero;
  logic          w_ge;
  logic [W:0]    w_diff;
  logic [FRAC:0] w_qNext;

  // Negating the most-negative value wraps to 2^(W-1), which is the
  // correct magnitude when read as unsigned.
  assign w_absRe    = bus.real_i[W-1] ? (~bus.real_i + W'(1)) : bus.real_i;
  assign w_absIm    = bus.imag_i[W-1] ? (~bus.imag_i + W'(1)) : bus.imag_i;
  assign w_imGtRe   = (r_absIm > r_absRe);
  assign w_bothZero = (r_absRe == '0) && (r_absIm == '0);

  assign w_ge    = (r_rem >= {1'b0, r_den});
  assign w_diff  = w_ge ? (r_rem - {1'b0, r_den}) : r_rem;
  assign w_qNext = {r_quo, w_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.val_i) w_next = PREP;
      PREP:    w_next = DIV;
      DIV:     if (r_cnt == '0) w_next = DONE;
      DONE:    if (bus.rdy_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_absRe <= '0;
      r_absIm <= '0;
      r_reNeg <= 1'b0;
      r_imNeg <= 1'b0;
      r_den   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_caseP <= '0;
      r_zeroP <= 1'b0;
      r_rdy   <= 1'b1;
      r_val   <= 1'b0;
      r_ratio <= '0;
      r_case  <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_rdy <= (w_next == IDLE);
      r_val <= (w_next == DONE);
      case (r_state)
        IDLE: begin
          if (bus.val_i) begin
            r_absRe <= w_absRe;
            r_absIm <= w_absIm;
            r_reNeg <= bus.real_i[W-1];
            r_imNeg <= bus.imag_i[W-1];
          end
        end
        PREP: begin
          r_rem   <= {1'b0, (w_imGtRe ? r_absRe : r_absIm)};
          r_den   <= w_imGtRe ? r_absIm : r_absRe;
          r_quo   <= '0;
          r_cnt   <= CW'(FRAC);
          r_caseP <= w_bothZero ? 3'b000 : {w_imGtRe, r_reNeg ^ r_imNeg, ~r_reNeg};
          r_zeroP <= w_bothZero;
        end
        DIV: begin
          // A zero divisor makes every step "succeed"; the zero flag masks it.
          r_rem <= w_diff << 1;
          r_quo <= w_qNext[FRAC-1:0];
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_ratio <= r_zeroP ? '0 : w_qNext;
            r_case  <= r_caseP;
            r_zero  <= r_zeroP;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rdy_o     = r_rdy;
  assign bus.val_o     = r_val;
  assign bus.ratio_o   = r_ratio;
  assign bus.case_flag = r_case;
  assign bus.zero_o    = r_zero;

endmodule

// File: tb/tb_octant_fold_div.sv
// Self-checking bench for octant_fold_div: directed corner samples plus a
// randomized run scored against an arithmetic model of the fold ratio.
module tb_octant_fold_div;

  localparam int W    = 8;
  localparam int FRAC = 7;
  localparam int LAT  = FRAC + 2;

  typedef struct {
    int ratio;
    int cf;
    int zero;
    int acceptEdge;
  } exp_t;

  logic clk;
  logic rst;

  octant_fold_div_if #(.W(W), .FRAC(FRAC)) bus();

  octant_fold_div #(.W(W), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t expQ[$];
  int   nChecks = 0;
  int   nErrors = 0;
  int   cyc     = 0;
  bit   randRdy = 1'b0;
  bit   prevVal = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected result straight from magnitudes: floor(min*2^FRAC/max).
  function automatic exp_t model(int re, int im, int edgeNo);
    exp_t e;
    int ar, ai, mn, mx;
    ar = (re < 0) ? -re : re;
    ai = (im < 0) ? -im : im;
    mx = (ar > ai) ? ar : ai;
    mn = (ar > ai) ? ai : ar;
    e.acceptEdge = edgeNo;
    if (mx == 0) begin
      e.ratio = 0;
      e.cf    = 0;
      e.zero  = 1;
    end else begin
      e.ratio = (mn * (1 << FRAC)) / mx;
      e.cf    = ((ai > ar) ? 4 : 0) + (((re < 0) != (im < 0)) ? 2 : 0) + ((re >= 0) ? 1 : 0);
      e.zero  = 0;
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    nChecks++;
    if (act != expv) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (randRdy) bus.rdy_i = ($urandom_range(0, 9) < 7);
  endtask

  task automatic applyStimulus(input int re, input int im);
    bit acc;
    bus.real_i = W'(re);
    bus.imag_i = W'(im);
    bus.val_i  = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = bus.rdy_o && !rst;
      tick();
    end
    bus.val_i = 1'b0;
    check("acceptTimeout", int'(acc), 1);
  endtask

  task automatic waitResult();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.val_o) begin
        found = 1'b1;
        break;
      end
    end
    check("resultTimeout", int'(found), 1);
  endtask

  task automatic checkOutput(input string name, input int r, input int c, input int z);
    check({name, "_ratio"}, int'(bus.ratio_o), r);
    check({name, "_case"},  int'(bus.case_flag), c);
    check({name, "_zero"},  int'(bus.zero_o), z);
  endtask

  // Scoreboard: pushes on every accept, compares while val_o is up, pops on consume.
  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        expQ.delete();
        prevVal = 1'b0;
      end else begin
        check("handshakeExclusive", int'(bus.val_o && bus.rdy_o), 0);
        if (bus.val_o) begin
          check("resultExpected", int'(expQ.size() > 0), 1);
          if (expQ.size() > 0) begin
            e = expQ[0];
            if (!prevVal) check("latency", cyc - e.acceptEdge, LAT);
            check("modelRatio", int'(bus.ratio_o), e.ratio);
            check("modelCase",  int'(bus.case_flag), e.cf);
            check("modelZero",  int'(bus.zero_o), e.zero);
            if (bus.rdy_i) void'(expQ.pop_front());
          end
        end
        if (bus.val_i && bus.rdy_o) begin
          expQ.push_back(model(int'($signed(bus.real_i)), int'($signed(bus.imag_i)), cyc + 1));
        end
        prevVal = bus.val_o;
      end
    end
  endtask

  function automatic int pickVal();
    case ($urandom_range(0, 7))
      0:       return -128;
      1:       return 0;
      2:       return 127;
      3:       return -1;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic mainFlow();
    bit seen;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("resetValO", int'(bus.val_o), 0);
    check("resetRdyO", int'(bus.rdy_o), 1);
    checkOutput("reset", 0, 0, 0);
    tick();

    bus.rdy_i = 1'b1;
    applyStimulus(64, 32);
    waitResult();
    checkOutput("re64im32", 64, 1, 0);
    tick();

    applyStimulus(-128, -128);
    waitResult();
    checkOutput("mostNeg", 128, 0, 0);
    tick();

    applyStimulus(0, 0);
    waitResult();
    checkOutput("bothZero", 0, 0, 1);
    tick();

    applyStimulus(3, -100);
    waitResult();
    checkOutput("re3imM100", 3, 7, 0);
    tick();

    // Stall in DONE while upstream keeps offering a new sample.
    bus.rdy_i = 1'b0;
    applyStimulus(-50, 20);
    bus.real_i = 8'sd5;
    bus.imag_i = 8'sd5;
    bus.val_i  = 1'b1;
    waitResult();
    checkOutput("stallFirst", 51, 2, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      check("stallValO", int'(bus.val_o), 1);
      check("stallRdyO", int'(bus.rdy_o), 0);
      check("stallRatio", int'(bus.ratio_o), 51);
    end
    tick();
    bus.rdy_i = 1'b1;
    bus.val_i = 1'b0;
    tick();
    @(negedge clk);
    check("consumeRdyO", int'(bus.rdy_o), 1);
    check("consumeValO", int'(bus.val_o), 0);
    tick();

    // Reset in the middle of the divide throws the sample away.
    applyStimulus(100, 37);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midResetValO", int'(bus.val_o), 0);
    check("midResetRdyO", int'(bus.rdy_o), 1);
    checkOutput("midReset", 0, 0, 0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.val_o) seen = 1'b1;
    end
    check("noResultAfterReset", int'(seen), 0);
    tick();

    randRdy = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        repeat ($urandom_range(1, 3)) tick();
      end
      applyStimulus(pickVal(), pickVal());
    end
    for (int k = 0; k < 500 && expQ.size() != 0; k++) tick();
    check("drainEmpty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  endtask

  initial begin
    rst        = 1'b1;
    bus.val_i  = 1'b0;
    bus.rdy_i  = 1'b0;
    bus.real_i = '0;
    bus.imag_i = '0;
    $display("[TB] octant_fold_div bench start");
    fork
      monitorLoop();
      mainFlow();
    join_any
  end

endmodule
